inst_queue: RTL and testbench

- Decoupling instruction buffer between the fetch unit and the decode unit.
- Accepts {pc, inst, err} beats from fetch over a valid/ready handshake and stores them in a circular FIFO. Presents the oldest entry to decode.
- Absorbs AXI fetch latency jitter and decode stalls.
- Provides a one-cycle flush for branch/exception redirect.

---
 rtl/inst_queue_pkg.sv | 16 +
 rtl/inst_queue_fifo_ram.sv | 29 ++
 rtl/inst_queue.sv | 93 +++++++++
 tb/tb_inst_queue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the fetch/decode front end.
package inst_queue_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h3000_0000;

    // One fetched beat as it travels from fetch to decode.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            err;
    } inst_beat_t;

    localparam int BEAT_W = $bits(inst_beat_t);

endpackage

// File: rtl/inst_queue_fifo_ram.sv
// Entry storage for the instruction queue: one write port, one asynchronous read port.
module fifo_ram
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [BEAT_W-1:0] wr_data,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [BEAT_W-1:0] rd_data
);

    logic [BEAT_W-1:0] mem [DEPTH];

    // Write the incoming beat into the slot addressed by the write pointer.
    // NOTE: the array has no reset; occupancy lives in the controller's count, so
    // stale contents are never presented and the array can map onto plain storage.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_queue.sv
// Decoupling buffer between fetch and decode: circular FIFO with a one-cycle flush.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_inst,
    input  logic            in_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst,
    output logic            out_err,
    input  logic            flush,
    output logic [PTR_W:0]  count
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;
    inst_beat_t        wr_beat;
    inst_beat_t        head;
    logic [BEAT_W-1:0] rd_data;

    // Handshake decode and head presentation; full/empty come from count only.
    // NOTE: every output of this block gets a value on every path, so no latch is inferred.
    always_comb begin
        in_ready  = reset && (count != FULL_CNT);
        out_valid = reset && (count != '0);
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready && !flush;

        wr_beat.pc   = in_pc;
        wr_beat.inst = in_inst;
        wr_beat.err  = in_err;

        head     = out_valid ? inst_beat_t'(rd_data) : '0;
        out_pc   = head.pc;
        out_inst = head.inst;
        out_err  = head.err;
    end

    // Pointer and occupancy update: reset, then flush, then push/pop.
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    fifo_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo_ram (
        .clock   (clock),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_beat),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic            clock;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_pc;
    logic [31:0]     in_inst;
    logic            in_err;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_pc;
    logic [31:0]     out_inst;
    logic            out_err;
    logic            flush;
    logic [PTR_W:0]  count;

    int tests_run = 0;
    int tests_failed = 0;
    bit started = 0;

    inst_beat_t  model[$];
    logic [31:0] popped[$];
    bit          last_push;
    bit          last_pop;

    inst_queue #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_err    (in_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .flush     (flush),
        .count     (count)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    // Occupancy must never leave 0..DEPTH.
    always @(negedge clock) begin
        if (started && reset === 1'b1) begin
            count_bound: assert (count <= (PTR_W+1)'(DEPTH))
                else $error("FAIL count_bound got=%0d max=%0d", count, DEPTH);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic er, input logic ordy, input logic fl, input logic rst);
        logic       exp_ir;
        logic       exp_ov;
        inst_beat_t hd;
        inst_beat_t nb;
        bit         do_push;
        bit         do_pop;
        in_valid  = iv;
        in_pc     = pc;
        in_inst   = ins;
        in_err    = er;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        #1;
        exp_ir = rst && (model.size() != DEPTH);
        exp_ov = rst && (model.size() != 0);
        hd     = exp_ov ? model[0] : '0;
        check("in_ready", in_ready, exp_ir);
        check("out_valid", out_valid, exp_ov);
        check("count", count, model.size());
        check("out_pc", out_pc, hd.pc);
        check("out_inst", out_inst, hd.inst);
        check("out_err", out_err, hd.err);
        do_push = iv && exp_ir && !fl;
        do_pop  = exp_ov && ordy && !fl;
        @(posedge clock);
        #1;
        last_push = do_push;
        last_pop  = do_pop;
        if (!rst || fl) begin
            model.delete();
        end else begin
            if (do_pop) begin
                popped.push_back(model[0].pc);
                void'(model.pop_front());
            end
            if (do_push) begin
                nb.pc   = pc;
                nb.inst = ins;
                nb.err  = er;
                model.push_back(nb);
            end
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, ordy, 1'b0, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && model.size() != 0; i++) begin
            idle(1'b1);
        end
        check("drained", count, 0);
    endtask

    logic [31:0] pc_next;

    initial begin
        in_valid = 0; in_pc = 0; in_inst = 0; in_err = 0;
        out_ready = 0; flush = 0; reset = 0;

        // Reset for 3 cycles, then idle.
        @(posedge clock);
        #1;
        started = 1;
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);

        // Fill to full with decode stalled; a fifth beat must be refused.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, RESET_PC + 32'(4 * i), NOP, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        cycle(1'b1, 32'h3000_0010, NOP, 1'b0, 1'b0, 1'b0, 1'b1);
        check("full_count", count, DEPTH);
        check("full_in_ready", in_ready, 1'b0);

        // Drain from full while pushing the next four PCs; pointers wrap.
        popped.delete();
        pc_next = 32'h3000_0010;
        for (int i = 0; i < 16 && pc_next != 32'h3000_0020; i++) begin
            cycle(1'b1, pc_next, NOP, 1'b0, 1'b1, 1'b0, 1'b1);
            if (last_push) pc_next += 32'd4;
        end
        check("drain_all_pushed", pc_next, 32'h3000_0020);
        drain();
        check("drain_beats", popped.size(), 8);
        for (int i = 0; i < popped.size() && i < 8; i++) begin
            check("drain_order", popped[i], RESET_PC + 32'(4 * i));
        end

        // Streaming at count=1: one beat in, one beat out every cycle.
        cycle(1'b1, 32'h3000_0100, NOP, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, 32'h3000_0100 + 32'(4 * i), 32'(i), 1'b0, 1'b1, 1'b0, 1'b1);
            check("stream_count", count, 1);
        end
        drain();

        // Flush with a concurrent push and pop at count=3.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h3000_0200 + 32'(4 * i), NOP, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        cycle(1'b1, 32'h8000_0000, NOP, 1'b0, 1'b1, 1'b1, 1'b1);
        check("flush_count", count, 0);
        check("flush_out_valid", out_valid, 1'b0);
        cycle(1'b1, 32'h8000_0004, NOP, 1'b0, 1'b0, 1'b0, 1'b1);
        check("flush_first_pc", out_pc, 32'h8000_0004);
        drain();

        // Error forwarding, then reset with two entries held.
        cycle(1'b1, 32'h3000_0040, 32'hdead_beef, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h3000_0044, NOP, 1'b0, 1'b0, 1'b0, 1'b1);
        check("err_pc", out_pc, 32'h3000_0040);
        check("err_flag", out_err, 1'b1);
        check("err_count", count, 2);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("mid_reset_count", count, 0);
        idle(1'b1);
        cycle(1'b1, 32'h3000_0050, NOP, 1'b0, 1'b0, 1'b0, 1'b1);
        check("post_reset_pc", out_pc, 32'h3000_0050);
        check("post_reset_err", out_err, 1'b0);
        drain();

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 23) == 0),
                  1'($urandom_range(0, 79) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout reached=1 expected=0");
        $fatal(1, "time limit");
    end

endmodule
